// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser: turns raw UART bytes into channel messages and a
// framed sysex payload FIFO, with running status, real-time filtering and backpressure.
module midi_byte_parser #(
  parameter int SYSEX_DEPTH = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] midi_out_midi_cmd,
  output logic [3:0] midi_out_midi_ch,
  output logic [6:0] midi_out_midi_data1,
  output logic [6:0] midi_out_midi_data2,
  output logic       midi_out_midi_valid,
  input  logic       midi_out_midi_rd,
  input  logic       midi_out_midi_busy,
  output logic [7:0] midi_out_sysex_data,
  output logic       midi_out_sysex_valid,
  input  logic       midi_out_sysex_rd,
  input  logic       midi_out_sysex_busy,
  output logic       midi_out_sysex_last,
  output logic [7:0] orphan_cnt
);
  // Handshake: a byte transfers on any rising clock edge where in_valid && in_ready;
  // in_ready is derived only from internal state and the consumer busy inputs.

  localparam int AW = $clog2(SYSEX_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  state_t      state, state_nx;
  logic [3:0]  rs_cmd, rs_cmd_nx, rs_ch, rs_ch_nx;
  logic [6:0]  d1_q, d1_nx;
  logic [7:0]  stg_data, stg_data_nx;
  logic        stg_full, stg_full_nx;
  logic        ready_en;
  logic        accept, load, push, push_last, orphan_inc;
  logic [6:0]  load_d1, load_d2;
  logic [7:0]  push_data;

  logic [8:0]  mem [SYSEX_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        fifo_full, fifo_empty, pop;
  logic [8:0]  head;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop        = midi_out_sysex_rd && !fifo_empty;
  assign head       = mem[rptr[AW-1:0]];

  // ready_en keeps in_ready low while reset is held and for the first cycle after
  assign in_ready = ready_en && !midi_out_midi_valid && !fifo_full
                    && !midi_out_midi_busy && !midi_out_sysex_busy;
  assign accept   = in_valid && in_ready;

  assign midi_out_sysex_valid = !fifo_empty;
  assign midi_out_sysex_data  = fifo_empty ? 8'h00 : head[7:0];
  assign midi_out_sysex_last  = fifo_empty ? 1'b0  : head[8];

  always_comb begin
    state_nx    = state;
    rs_cmd_nx   = rs_cmd;
    rs_ch_nx    = rs_ch;
    d1_nx       = d1_q;
    stg_data_nx = stg_data;
    stg_full_nx = stg_full;
    load        = 1'b0;
    load_d1     = (state == WAIT_D2) ? d1_q : in_data[6:0];
    load_d2     = 7'd0;
    push        = 1'b0;
    push_data   = stg_data;
    push_last   = 1'b0;
    orphan_inc  = 1'b0;
    if (accept) begin
      if (in_data[7:3] == 5'b11111) begin
        // real-time bytes pass through without touching any parser state
      end else if (!in_data[7]) begin
        case (state)
          IDLE:    orphan_inc = 1'b1;
          WAIT_D1: begin
            d1_nx = in_data[6:0];
            if (rs_cmd == 4'hC || rs_cmd == 4'hD) load = 1'b1;
            else state_nx = WAIT_D2;
          end
          WAIT_D2: begin
            load     = 1'b1;
            load_d2  = in_data[6:0];
            state_nx = WAIT_D1;
          end
          default: begin
            push        = stg_full;
            stg_data_nx = in_data;
            stg_full_nx = 1'b1;
          end
        endcase
      end else if (in_data == 8'hF7) begin
        if (state == SYSEX) begin
          push        = stg_full;
          push_last   = 1'b1;
          stg_full_nx = 1'b0;
          state_nx    = IDLE;
        end
      end else begin
        // any other status closes an open sysex, marking the held byte as final
        if (state == SYSEX) begin
          push      = stg_full;
          push_last = 1'b1;
        end
        stg_full_nx = 1'b0;
        if (in_data[7:4] != 4'hF) begin
          rs_cmd_nx = in_data[7:4];
          rs_ch_nx  = in_data[3:0];
          state_nx  = WAIT_D1;
        end else begin
          rs_cmd_nx = 4'h0;
          rs_ch_nx  = 4'h0;
          state_nx  = (in_data == 8'hF0) ? SYSEX : IDLE;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      rs_cmd   <= 4'h0;
      rs_ch    <= 4'h0;
      d1_q     <= 7'd0;
      stg_data <= 8'h00;
      stg_full <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nx;
      rs_cmd   <= rs_cmd_nx;
      rs_ch    <= rs_ch_nx;
      d1_q     <= d1_nx;
      stg_data <= stg_data_nx;
      stg_full <= stg_full_nx;
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      midi_out_midi_valid <= 1'b0;
      midi_out_midi_cmd   <= 4'h0;
      midi_out_midi_ch    <= 4'h0;
      midi_out_midi_data1 <= 7'd0;
      midi_out_midi_data2 <= 7'd0;
      orphan_cnt          <= 8'd0;
    end else begin
      if (load) begin
        midi_out_midi_valid <= 1'b1;
        midi_out_midi_cmd   <= rs_cmd;
        midi_out_midi_ch    <= rs_ch;
        midi_out_midi_data1 <= load_d1;
        midi_out_midi_data2 <= load_d2;
      end else if (midi_out_midi_rd && midi_out_midi_valid) begin
        midi_out_midi_valid <= 1'b0;
      end
      if (orphan_inc && orphan_cnt != 8'hFF) orphan_cnt <= orphan_cnt + 8'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wptr[AW-1:0]] <= {push_last, push_data};
  end

endmodule

// File: tb/tb_midi_byte_parser.sv
// Directed bench for midi_byte_parser: table of channel-message vectors plus
// hand-written sysex, orphan, backpressure and reset sequences.
module tb_midi_byte_parser;
  localparam int DEPTH = 16;
  localparam int LIMIT = 200;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cmd, ch;
  logic [6:0] d1, d2;
  logic       midi_valid, midi_rd, midi_busy;
  logic [7:0] sx_data;
  logic       sx_valid, sx_rd, sx_busy, sx_last;
  logic [7:0] orphan_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] b [4];
    int         n;
    logic [3:0] cmd, ch;
    logic [6:0] d1, d2;
  } vec_t;
  vec_t vecs [9];

  always #5 aclk = ~aclk;

  midi_byte_parser #(.SYSEX_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .midi_out_midi_cmd(cmd), .midi_out_midi_ch(ch),
    .midi_out_midi_data1(d1), .midi_out_midi_data2(d2),
    .midi_out_midi_valid(midi_valid), .midi_out_midi_rd(midi_rd),
    .midi_out_midi_busy(midi_busy),
    .midi_out_sysex_data(sx_data), .midi_out_sysex_valid(sx_valid),
    .midi_out_sysex_rd(sx_rd), .midi_out_sysex_busy(sx_busy),
    .midi_out_sysex_last(sx_last), .orphan_cnt(orphan_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] bytes,
                              input logic [3:0] c, input logic [3:0] h,
                              input logic [6:0] a, input logic [6:0] b);
    vec_t v;
    for (int i = 0; i < 4; i++) v.b[i] = bytes[31-8*i -: 8];
    v.n = n; v.cmd = c; v.ch = h; v.d1 = a; v.d2 = b;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < LIMIT) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("in_ready_timeout", 32'(n < LIMIT), 32'd1);
    @(posedge aclk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_msg(input logic [3:0] c, input logic [3:0] h,
                            input logic [6:0] a, input logic [6:0] b);
    chk("midi_valid", 32'(midi_valid), 32'd1);
    chk("midi_cmd", 32'(cmd), 32'(c));
    chk("midi_ch", 32'(ch), 32'(h));
    chk("midi_d1", 32'(d1), 32'(a));
    chk("midi_d2", 32'(d2), 32'(b));
    chk("in_ready_held", 32'(in_ready), 32'd0);
    midi_rd = 1'b1;
    @(posedge aclk); #1;
    midi_rd = 1'b0;
    chk("midi_valid_clr", 32'(midi_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic expect_pop();
    logic [8:0] e;
    e = exp_q.pop_front();
    chk("sysex_valid", 32'(sx_valid), 32'd1);
    chk("sysex_data", 32'(sx_data), 32'(e[7:0]));
    chk("sysex_last", 32'(sx_last), 32'(e[8]));
    sx_rd = 1'b1;
    @(posedge aclk); #1;
    sx_rd = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_msg"}, {13'd0, midi_valid, cmd, ch, d1, d2}, 32'd0);
    chk({tag, "_sysex"}, {22'd0, sx_valid, sx_last, sx_data}, 32'd0);
    chk({tag, "_orphan"}, 32'(orphan_cnt), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);
  endtask

  initial begin
    aresetn = 1'b1; in_data = 8'h00; in_valid = 1'b0;
    midi_rd = 1'b0; midi_busy = 1'b0; sx_rd = 1'b0; sx_busy = 1'b0;
    vecs[0] = mk(3, 32'h903C6400, 4'h9, 4'h0, 7'h3C, 7'h64);
    vecs[1] = mk(3, 32'h933C6400, 4'h9, 4'h3, 7'h3C, 7'h64);
    vecs[2] = mk(2, 32'h3E000000, 4'h9, 4'h3, 7'h3E, 7'h00);
    vecs[3] = mk(2, 32'hC5070000, 4'hC, 4'h5, 7'h07, 7'h00);
    vecs[4] = mk(2, 32'hF8080000, 4'hC, 4'h5, 7'h08, 7'h00);
    vecs[5] = mk(3, 32'hD2F85500, 4'hD, 4'h2, 7'h55, 7'h00);
    vecs[6] = mk(3, 32'hE1004000, 4'hE, 4'h1, 7'h00, 7'h40);
    vecs[7] = mk(4, 32'hA4FE3C10, 4'hA, 4'h4, 7'h3C, 7'h10);
    vecs[8] = mk(3, 32'hB0077F00, 4'hB, 4'h0, 7'h07, 7'h7F);

    do_reset();

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        send_byte(vecs[i].b[j]);
        if (j < vecs[i].n - 1) chk("midi_valid_early", 32'(midi_valid), 32'd0);
      end
      expect_msg(vecs[i].cmd, vecs[i].ch, vecs[i].d1, vecs[i].d2);
    end

    // sysex with an interleaved real-time byte
    exp_q.push_back({1'b0, 8'h7E});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h02});
    send_byte(8'hF0); send_byte(8'h7E); send_byte(8'h01);
    send_byte(8'hF8); send_byte(8'h02); send_byte(8'hF7);
    chk("sysex_no_msg", 32'(midi_valid), 32'd0);
    repeat (3) expect_pop();
    chk("sysex_drained", 32'(sx_valid), 32'd0);

    // sysex aborted by a channel status
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    send_byte(8'hF0); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h80); send_byte(8'h40); send_byte(8'h00);
    expect_msg(4'h8, 4'h0, 7'h40, 7'h00);
    repeat (2) expect_pop();
    chk("abort_drained", 32'(sx_valid), 32'd0);

    midi_busy = 1'b1; #1;
    chk("midi_busy_stall", 32'(in_ready), 32'd0);
    midi_busy = 1'b0; sx_busy = 1'b1; #1;
    chk("sysex_busy_stall", 32'(in_ready), 32'd0);
    sx_busy = 1'b0; #1;
    chk("busy_release", 32'(in_ready), 32'd1);

    // orphans and saturation
    do_reset();
    send_byte(8'h40); send_byte(8'h41);
    chk("orphan_two", 32'(orphan_cnt), 32'd2);
    chk("orphan_no_msg", 32'(midi_valid), 32'd0);
    repeat (253) send_byte(8'h00);
    chk("orphan_255", 32'(orphan_cnt), 32'd255);
    send_byte(8'h12);
    chk("orphan_sat", 32'(orphan_cnt), 32'd255);

    // FIFO fill: staging holds one byte, so DEPTH+1 data bytes fill the FIFO
    for (int i = 1; i <= DEPTH + 2; i++)
      exp_q.push_back({(i == DEPTH + 2), 8'(i + 16)});
    send_byte(8'hF0);
    for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i + 16));
    chk("fifo_full_stall", 32'(in_ready), 32'd0);
    in_data  = 8'(DEPTH + 18);
    in_valid = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("fifo_full_hold", 32'(in_ready), 32'd0);
    expect_pop();
    chk("fifo_room", 32'(in_ready), 32'd1);
    @(posedge aclk); #1;
    in_valid = 1'b0;
    chk("fifo_full_again", 32'(in_ready), 32'd0);
    repeat (DEPTH) expect_pop();
    send_byte(8'hF7);
    expect_pop();
    chk("fifo_empty_end", 32'(sx_valid), 32'd0);
    chk("fifo_exp_used", 32'(exp_q.size()), 32'd0);

    // asynchronous reset in the middle of a sysex
    send_byte(8'hF0); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    chk("mid_sysex_valid", 32'(sx_valid), 32'd1);
    #3 aresetn = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge aclk); #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    send_byte(8'h05);
    chk("post_reset_orphan", 32'(orphan_cnt), 32'd1);
    send_byte(8'hF7);
    chk("post_reset_no_sysex", 32'(sx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/midi_byte_parser.md
Name: midi_byte_parser

Overview:
Upstream stage of the MIDI processing chain. Converts a raw MIDI byte stream from the UART receiver into the parsed channel-message interface (cmd/ch/data1/data2) and the sysex byte-stream interface consumed by transform stages such as the note transposer. Handles running status, interleaved real-time bytes and sysex framing, with backpressure toward the byte source.

Parameters:
SYSEX_DEPTH, 16, sysex FIFO depth in bytes; power of two, >= 2.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
in_data  in  8  raw MIDI byte from UART receiver
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted on a cycle with in_valid && in_ready
midi_out_midi_cmd  out  4  status high nibble (8..E)
midi_out_midi_ch  out  4  status low nibble
midi_out_midi_data1  out  7  first data byte
midi_out_midi_data2  out  7  second data byte; 0 for 1-data messages
midi_out_midi_valid  out  1  message register holds an unread message
midi_out_midi_rd  in  1  consumer read strobe
midi_out_midi_busy  in  1  consumer cannot accept; stall byte input
midi_out_sysex_data  out  8  sysex FIFO head byte (payload only; F0/F7 excluded)
midi_out_sysex_valid  out  1  FIFO not empty
midi_out_sysex_rd  in  1  pop strobe
midi_out_sysex_busy  in  1  consumer cannot accept; stall byte input
midi_out_sysex_last  out  1  head byte is final payload byte of its sysex message
orphan_cnt  out  8  saturating count of discarded data bytes

Behaviour:
- Reset (aresetn low, async): all outputs 0, in_ready 0; state IDLE; running status cleared; staging empty; FIFO empty; orphan_cnt 0. Reset mid-message or mid-sysex discards all partial content; FIFO contents lost.
- in_ready = !midi_out_midi_valid && !fifo_full && !midi_out_midi_busy && !midi_out_sysex_busy; registered-input-independent (never depends on in_data).
- States: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX.
- Byte 0x80-0xEF (any state): set running status (cmd = b[7:4], ch = b[3:0]); go WAIT_D1. Expected data count 1 for cmd C/D, otherwise 2. If in SYSEX, first close sysex (see abort).
- Data byte (b[7]=0): WAIT_D1 -> store data1; 1-byte cmd completes, else WAIT_D2. WAIT_D2 -> store data2, complete. IDLE -> discard, orphan_cnt += 1 (saturate at 255). SYSEX -> see sysex.
- Completion: message register loaded, midi_out_midi_valid = 1 the cycle after the completing byte is accepted; state returns to WAIT_D1 (running status kept). Note-on velocity 0 passed unchanged.
- midi_out_midi_rd && midi_out_midi_valid clears valid next cycle; rd while !valid ignored. Load and read cannot coincide (in_ready low while valid).
- 0xF0: enter SYSEX, clear running status, staging empty.
- SYSEX data byte: if staging full, push staged byte with last=0; staged <= byte.
- 0xF7 in SYSEX: push staged with last=1 (nothing if staging empty); go IDLE. 0xF7 outside SYSEX: ignored.
- Sysex abort by any status 0x80-0xEF or 0xF1-0xF6: push staged with last=1 (if any), then process byte normally.
- 0xF1-0xF6: clear running status, go IDLE; their data bytes count as orphans.
- 0xF8-0xFF (real-time): accepted and ignored in every state; no state, staging or running-status change.
- At most one FIFO push per accepted byte; fifo_full gating guarantees no overflow.
- FIFO first-word fall-through: data/last show head; pop on sysex_rd && sysex_valid; push and pop same cycle allowed; pointers wrap modulo SYSEX_DEPTH. sysex_valid rises the cycle after push.

Test Plan:
- Bytes 90 3C 64, rd held 0 -> valid=1 one cycle after 64: cmd 9, ch 0, d1 3C, d2 64; in_ready 0 until rd pulse, then valid 0.
- Running status 93 3C 64 3E 00, rd pulsed per message -> two messages (9,3,3C,64) and (9,3,3E,00).
- C5 07 F8 08 -> (C,5,07,00) then (C,5,08,00); F8 no effect.
- F0 7E 01 F8 02 F7 -> FIFO pops 7E(last 0), 01(last 0), 02(last 1); no midi_valid.
- F0 11 22 80 40 00 -> FIFO 11(last 0), 22(last 1); then message (8,0,40,00).
- After reset: 40 41 -> orphan_cnt 2, no valid; 256 orphans -> orphan_cnt 255; SYSEX_DEPTH+2 sysex bytes with sysex_rd 0 -> in_ready low once FIFO full, no byte lost after draining; reset asserted mid-sysex -> all outputs 0 asynchronously.
